// File: rtl/riscv_kernel_pkg.sv
// Shared RV32I encodings, ALU operation set and the two-phase memory sequencing state.
package riscv_kernel_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Register/immediate ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Word-sized load/store funct3
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic {
        PH_ISSUE,
        PH_ACCESS
    } mem_phase_e;

    // Map funct3 plus the instr[30] alternate bit onto an ALU operation.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_kernel_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port, x0 fixed at zero.
module riscv_kernel_regfile
    import riscv_kernel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next register contents: apply the single write, keep x0 at zero.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register storage with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs1_data = regs_q[rs1_addr];
    assign rs2_data = regs_q[rs2_addr];

endmodule

// File: rtl/riscv_kernel.sv
// Minimal in-order RV32I core: single-cycle ALU/branch/jump, two-phase LW/SW against
// falling-edge synchronous instruction and data memories.
module riscv_kernel
    import riscv_kernel_pkg::*;
#(
    parameter int unsigned IMEM_AW  = 6,
    parameter int unsigned DMEM_AW  = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_address0,
    output logic               imem_ce0,
    input  logic [31:0]        imem_q0,
    output logic [DMEM_AW-1:0] dmem_address0,
    output logic               dmem_ce0,
    output logic               dmem_we0,
    output logic [31:0]        dmem_d0,
    input  logic [31:0]        dmem_q0
);

    logic [31:0] pc_q, pc_d;
    mem_phase_e  mem_phase_q, mem_phase_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    logic        is_lw, is_sw, is_mem;
    alu_op_e     alu_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        wb_en, wb_link;
    logic        br_taken;

    logic [31:0] pc_plus4, jalr_sum, eff_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        unused_addr_bits;

    assign instr  = imem_q0;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign is_lw  = (opcode == OP_LOAD)  && (funct3 == F3_LW);
    assign is_sw  = (opcode == OP_STORE) && (funct3 == F3_SW);
    assign is_mem = is_lw || is_sw;

    assign pc_plus4 = pc_q + 32'd4;
    assign jalr_sum = rs1_val + imm_i;
    assign eff_addr = rs1_val + (is_sw ? imm_s : imm_i);

    riscv_kernel_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (rf_wdata)
    );

    // Decode: choose ALU operation, operands and whether rd is written.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_a   = rs1_val;
        alu_b   = imm_i;
        wb_en   = 1'b0;
        wb_link = 1'b0;
        case (opcode)
            OP_LUI: begin
                alu_op = ALU_PASS_B;
                alu_b  = imm_u;
                wb_en  = 1'b1;
            end
            OP_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                wb_en = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                wb_en   = 1'b1;
                wb_link = 1'b1;
            end
            OP_IMM: begin
                // Only the right shifts use instr[30]; ADDI never becomes a subtract.
                alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && instr[30]);
                wb_en  = 1'b1;
            end
            OP_OP: begin
                alu_op = alu_from_f3(funct3, instr[30]);
                alu_b  = rs2_val;
                wb_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU: 32-bit wrap-around arithmetic, shift amount from the low five bits of b.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:    alu_res = alu_a + alu_b;
            ALU_SUB:    alu_res = alu_a - alu_b;
            ALU_SLL:    alu_res = alu_a << alu_b[4:0];
            ALU_SLT:    alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_res = {31'b0, alu_a < alu_b};
            ALU_XOR:    alu_res = alu_a ^ alu_b;
            ALU_SRL:    alu_res = alu_a >> alu_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:     alu_res = alu_a | alu_b;
            ALU_AND:    alu_res = alu_a & alu_b;
            ALU_PASS_B: alu_res = alu_b;
            default:    alu_res = '0;
        endcase
    end

    // Branch condition from rs1/rs2; reserved funct3 values never branch.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val <  rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Next pc, memory phase and register write-back.
    always_comb begin
        pc_d        = pc_q;
        mem_phase_d = mem_phase_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_res;
        if (is_mem) begin
            // Holding pc in the issue phase keeps imem re-reading the same word,
            // so the access phase sees a stable instruction for the whole cycle.
            if (mem_phase_q == PH_ISSUE) begin
                mem_phase_d = PH_ACCESS;
            end else begin
                mem_phase_d = PH_ISSUE;
                pc_d        = pc_plus4;
                rf_we       = is_lw;
                rf_wdata    = dmem_q0;
            end
        end else begin
            rf_we    = wb_en;
            rf_wdata = wb_link ? pc_plus4 : alu_res;
            case (opcode)
                OP_JAL:    pc_d = pc_q + imm_j;
                OP_JALR:   pc_d = {jalr_sum[31:1], 1'b0};
                OP_BRANCH: pc_d = br_taken ? (pc_q + imm_b) : pc_plus4;
                default:   pc_d = pc_plus4;
            endcase
        end
    end

    // Architectural state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            mem_phase_q <= PH_ISSUE;
        end else begin
            pc_q        <= pc_d;
            mem_phase_q <= mem_phase_d;
        end
    end

    assign imem_ce0      = rst;
    assign imem_address0 = rst ? pc_q[IMEM_AW+1:2] : '0;

    assign dmem_ce0      = rst && is_mem && (mem_phase_q == PH_ACCESS);
    assign dmem_we0      = dmem_ce0 && is_sw;
    assign dmem_address0 = eff_addr[DMEM_AW+1:2];
    assign dmem_d0       = rs2_val;

    assign unused_addr_bits = ^{eff_addr[31:DMEM_AW+2], eff_addr[1:0]};

endmodule

// File: tb/tb_riscv_kernel.sv
// Scoreboard bench for riscv_kernel: directed programs, expected per-cycle fetch/data-port
// behaviour and expected data-memory writes queued at issue, compared by a monitor.
module tb_riscv_kernel;

    localparam int IMEM_AW = 6;
    localparam int DMEM_AW = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OPI   = 'h13;
    localparam int LUI   = 'h37;
    localparam int AUIPC = 'h17;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [IMEM_AW-1:0] imem_address0;
    logic               imem_ce0;
    logic [31:0]        imem_q0 = '0;
    logic [DMEM_AW-1:0] dmem_address0;
    logic               dmem_ce0;
    logic               dmem_we0;
    logic [31:0]        dmem_d0;
    logic [31:0]        dmem_q0 = '0;

    logic [31:0] imem     [64];
    logic [31:0] dmem     [32];
    logic [31:0] dmem_img [32];
    logic        dmem_load = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ice;
        logic [5:0]  ia;
        logic        dce;
        logic        dwe;
        logic        chk_a;
        logic        chk_d;
        logic [4:0]  da;
        logic [31:0] dd;
    } trace_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    trace_t trace_q[$];
    wr_t    wr_q[$];

    riscv_kernel #(
        .IMEM_AW  (IMEM_AW),
        .DMEM_AW  (DMEM_AW),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_address0 (imem_address0),
        .imem_ce0      (imem_ce0),
        .imem_q0       (imem_q0),
        .dmem_address0 (dmem_address0),
        .dmem_ce0      (dmem_ce0),
        .dmem_we0      (dmem_we0),
        .dmem_d0       (dmem_d0),
        .dmem_q0       (dmem_q0)
    );

    always #5 clk = ~clk;

    // Falling-edge synchronous memories; dmem image is copied in on request.
    always @(negedge clk) begin
        if (imem_ce0) imem_q0 <= imem[imem_address0];
        if (dmem_load) begin
            dmem <= dmem_img;
        end else if (dmem_ce0) begin
            if (dmem_we0) dmem[dmem_address0] <= dmem_d0;
            dmem_q0 <= dmem[dmem_address0];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: late in each cycle, pop the expected port state and any expected write.
    always @(negedge clk) begin
        trace_t t;
        wr_t    w;
        #2;
        if (trace_q.size() != 0) begin
            t = trace_q.pop_front();
            check("port_ctl", {22'd0, imem_ce0, 6'(imem_address0), dmem_ce0, dmem_we0},
                  {22'd0, t.ice, t.ia, t.dce, t.dwe});
            if (t.chk_a) check("dmem_addr", {27'd0, dmem_address0}, {27'd0, t.da});
            if (t.chk_d) check("dmem_d", dmem_d0, t.dd);
        end
        if (rst && dmem_ce0 && dmem_we0) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, required no write",
                         dmem_address0, dmem_d0);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", {27'd0, dmem_address0}, {27'd0, w.a});
                check("wr_data", dmem_d0, w.d);
            end
        end
    end

    function automatic logic [31:0] i_t(int op, int f3, int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] r_t(int f7, int f3, int rd, int rs1, int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] s_t(int rs1, int rs2, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lw_t(int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
    endfunction
    function automatic logic [31:0] b_t(int f3, int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(int op, int rd, int imm20);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] j_t(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] jalr_t(int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h67};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tr(input logic ice, input int ia, input logic dce, input logic dwe,
                           input logic ca, input logic cd, input int da, input logic [31:0] dd);
        trace_t t;
        t.ice = ice; t.ia = ia[5:0]; t.dce = dce; t.dwe = dwe;
        t.chk_a = ca; t.chk_d = cd; t.da = da[4:0]; t.dd = dd;
        trace_q.push_back(t);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t w;
        w.a = a[4:0];
        w.d = d;
        wr_q.push_back(w);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        for (int i = 0; i < 32; i++) dmem_img[i] = '0;
    endtask

    // Two reset cycles with outputs expected quiet; dmem image is loaded meanwhile.
    task automatic do_reset();
        rst = 1'b0;
        dmem_load = 1'b1;
        push_tr(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_tr(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        cycle();
        dmem_load = 1'b0;
        cycle();
    endtask

    task automatic wait_drain(input int budget, input int settle);
        int n;
        n = 0;
        while ((trace_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (trace_q.size() != 0 || wr_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d trace and %0d writes left, required 0",
                     trace_q.size(), wr_q.size());
            trace_q.delete();
            wr_q.delete();
        end
        repeat (settle) cycle();
    endtask

    int          sreg [21] = '{1, 2, 3, 0, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21};
    logic [31:0] sval [21] = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'h1, 32'h0, 32'hFFFFFFFC, 32'h6,
                               32'h7FFFFFFD, 32'h1, 32'h20000000, 32'h4, 32'hF0, 32'h101,
                               32'h12345000, 32'h1034, 32'h1, 32'h1, 32'hFFFFFFF8, 32'h7,
                               32'hFFFFFFFD, 32'hF, 32'h80000000};
    int          br_ia [16] = '{0, 2, 5, 3, 4, 6, 6, 7, 8, 10, 11, 13, 14, 14, 15, 15};
    logic [31:0] swap_init [10] = '{2, 13, 24, 6, 1, 5, 8, 7, 3, 44};
    logic [31:0] swap_exp  [10] = '{1, 5, 8, 7, 2, 13, 24, 6, 3, 44};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // Reset and sequential fetch over NOPs.
        clear_mems();
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) push_tr(1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        wait_drain(20, 0);

        // ALU coverage, results stored to words 0..20.
        clear_mems();
        imem[0]  = i_t(OPI, 0, 1, 0, -5);
        imem[1]  = i_t(OPI, 5, 2, 1, 'h401);
        imem[2]  = r_t(0, 3, 3, 0, 1);
        imem[3]  = i_t(OPI, 0, 0, 0, 7);
        imem[4]  = r_t(0, 0, 4, 1, 3);
        imem[5]  = r_t(32, 0, 6, 3, 1);
        imem[6]  = r_t(0, 5, 7, 1, 3);
        imem[7]  = r_t(0, 2, 8, 1, 3);
        imem[8]  = r_t(0, 1, 9, 3, 2);
        imem[9]  = i_t(OPI, 4, 10, 1, -1);
        imem[10] = i_t(OPI, 7, 11, 1, 'hF0);
        imem[11] = i_t(OPI, 6, 12, 3, 'h100);
        imem[12] = u_t(LUI, 13, 'h12345);
        imem[13] = u_t(AUIPC, 14, 1);
        imem[14] = i_t(OPI, 2, 15, 1, -4);
        imem[15] = i_t(OPI, 3, 16, 3, -1);
        imem[16] = r_t(0, 7, 17, 1, 4);
        imem[17] = r_t(0, 6, 18, 3, 6);
        imem[18] = r_t(0, 4, 19, 1, 6);
        imem[19] = i_t(OPI, 5, 20, 1, 28);
        imem[20] = i_t(OPI, 1, 21, 3, 31);
        for (int i = 0; i < 21; i++) imem[21 + i] = s_t(0, sreg[i], 4 * i);
        imem[42] = j_t(0, 0);
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 21; i++) push_wr(i, sval[i]);
        wait_drain(200, 10);

        // Load / increment / store with two-cycle data accesses.
        clear_mems();
        dmem_img[4] = 32'd1;
        imem[0] = lw_t(5, 0, 16);
        imem[1] = i_t(OPI, 0, 5, 5, 1);
        imem[2] = s_t(0, 5, 16);
        imem[3] = j_t(0, 0);
        do_reset();
        rst = 1'b1;
        push_tr(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_tr(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 4, '0);
        push_tr(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_tr(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_tr(1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 4, 32'd2);
        push_tr(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_tr(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        push_wr(4, 32'd2);
        wait_drain(40, 2);
        check("ldst_word4", dmem[4], 32'd2);

        // Branches, JAL link, JALR with bit 0 cleared, registers cleared by reset.
        clear_mems();
        imem[0]  = b_t(0, 0, 0, 8);
        imem[1]  = i_t(OPI, 0, 2, 0, 1);
        imem[2]  = j_t(1, 12);
        imem[3]  = b_t(1, 0, 0, 8);
        imem[4]  = j_t(0, 8);
        imem[5]  = jalr_t(0, 1, 1);
        imem[6]  = s_t(0, 1, 0);
        imem[7]  = i_t(OPI, 0, 2, 0, -1);
        imem[8]  = b_t(4, 2, 0, 8);
        imem[9]  = i_t(OPI, 0, 3, 0, 9);
        imem[10] = b_t(6, 2, 0, 8);
        imem[11] = b_t(5, 0, 2, 8);
        imem[12] = i_t(OPI, 0, 3, 0, 9);
        imem[13] = b_t(7, 0, 2, 8);
        imem[14] = s_t(0, 3, 4);
        imem[15] = j_t(0, 0);
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 6)       push_tr(1'b1, br_ia[i], 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'd12);
            else if (i == 13) push_tr(1'b1, br_ia[i], 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'd0);
            else              push_tr(1'b1, br_ia[i], 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        end
        push_wr(0, 32'd12);
        push_wr(1, 32'd0);
        wait_drain(40, 5);

        // Two-block swap program ending in a self-loop.
        clear_mems();
        for (int i = 0; i < 10; i++) dmem_img[i] = swap_init[i];
        imem[0] = i_t(OPI, 0, 1, 0, 0);
        imem[1] = i_t(OPI, 0, 4, 0, 16);
        imem[2] = lw_t(2, 1, 0);
        imem[3] = lw_t(3, 1, 16);
        imem[4] = s_t(1, 3, 0);
        imem[5] = s_t(1, 2, 16);
        imem[6] = i_t(OPI, 0, 1, 1, 4);
        imem[7] = b_t(1, 1, 4, -20);
        imem[8] = j_t(0, 0);
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_wr(i, swap_init[i + 4]);
            push_wr(i + 4, swap_init[i]);
        end
        wait_drain(2000, 40);
        for (int i = 0; i < 10; i++) check($sformatf("swap_word%0d", i), dmem[i], swap_exp[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_kernel.md
Name: riscv_kernel

Overview:
- Minimal in-order RV32I integer core; one instruction in flight.
- Fetches from an external synchronous word-wide instruction ROM and accesses an external synchronous word-wide data RAM.
- Both memories are clocked on the falling edge of clk, so a read issued in the first half of a cycle returns data before the next rising edge.
- Runs from reset with no start/done handshake; the program is expected to end in a self-loop.

Parameters:
- IMEM_AW, 6, instruction memory word-address width.
- DMEM_AW, 5, data memory word-address width.
- RESET_PC, 32'h0, byte address fetched first after reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_address0  out  IMEM_AW  word address = pc[IMEM_AW+1:2].
- imem_ce0  out  1  instruction fetch enable.
- imem_q0  in  32  instruction word; registered by the memory on the falling edge.
- dmem_address0  out  DMEM_AW  word address = effective_addr[DMEM_AW+1:2].
- dmem_ce0  out  1  data access enable.
- dmem_we0  out  1  data write enable, qualified by dmem_ce0.
- dmem_d0  out  32  store data = rs2 value.
- dmem_q0  in  32  load data; registered by the memory on the falling edge.

Behaviour:
- Reset (rst=0 at a rising edge):
  - pc <= RESET_PC; x1..x31 <= 0; mem_phase <= 0.
  - While rst=0: imem_ce0=0, dmem_ce0=0, dmem_we0=0, imem_address0=0.
- Out of reset: imem_ce0=1 every cycle. The current instruction is imem_q0 as decoded combinationally.
- Non-memory instructions: 1 cycle each. rd and pc are written at the rising edge ending the cycle. pc advances to pc+4 or to the branch/jump target.
- LW/SW: 2 cycles, sequenced by mem_phase.
  - Phase 0: dmem_ce0=0; pc held; mem_phase <= 1.
  - Phase 1: dmem_ce0=1; address/data/we from the current instruction; dmem_we0=1 only for SW.
  - Phase 1 LW: rd <= dmem_q0 at the closing edge.
  - End of phase 1: pc <= pc+4; mem_phase <= 0.
  - pc is held in phase 0, so imem re-reads the same word and the instruction stays stable.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic: 32-bit, wrap-around, no traps. Shift amount is the low 5 bits. Immediates are sign-extended per RV32I format.
- x0 reads 0 and writes to it are discarded. Register reads are combinational, so write-then-read in consecutive cycles sees the new value.
- Other opcodes, byte/half loads/stores, FENCE and SYSTEM execute as NOP (pc+4). No exceptions.
- Address wrap: effective and pc addresses are truncated to the memory width; upper bits are ignored.
- A self-loop (JAL x0,0) repeats forever with no side effects.
- Reset asserted mid-LW/SW: the access is abandoned, no rd write, and state returns to reset values.

Decomposition:
- Package riscv_kernel_pkg: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP), funct3/funct7 constants, alu_op_e enum.
- One sub-module, riscv_kernel_regfile: 32x32, two combinational read ports, one write port, x0 hardwired to zero.
- Decode, ALU, branch compare and the pc/mem_phase sequencing stay in riscv_kernel.

Test Plan:
- Reset/fetch: hold rst=0 for 2 cycles, then release → imem_address0=0 in the first cycle, then 1, 2, … one per cycle; dmem_ce0=0 throughout.
- ALU: ADDI x1,x0,-5; SRAI x2,x1,1; SLTU x3,x0,x1 → x1=0xFFFFFFFB, x2=0xFFFFFFFD, x3=1; ADDI x0,x0,7 leaves x0=0.
- Load/store: dmem word 4 = 1; LW x5,16(x0); ADDI x5,x5,1; SW x5,16(x0) → LW spends 2 cycles with dmem_address0=4; dmem_ce0=1 only in the second cycle of each access; dmem_we0=1 with dmem_d0=2 only in the SW second cycle; word 4 = 2.
- Branches/jumps: BEQ taken (+8), BNE not taken, JAL x1,+12 at pc 8, JALR x0,0(x1) → pc sequence matches; x1=12.
- Program: dmem = [2,13,24,6,1,5,8,7,3,44]; run the two-block-swap program (LW/SW loop over words 0-3 and 4-7, ending in a self-loop) → dmem = [1,5,8,7,2,13,24,6,3,44] within 100000 ns at a 10 ns clock; no further writes after the self-loop is reached.
